// File: rtl/m5_key_matrix.sv
// rtl/m5_key_matrix.sv - M5 keyboard matrix fed by PS/2 events with minimum-hold deferred release
module m5_key_matrix #(
  parameter logic [15:0] MIN_HOLD   = 16'd10700,
  parameter int          RELQ_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [10:0] ps2_key_i,
  input  logic        clear_i,
  input  logic [2:0]  row_sel_i,
  output logic [7:0]  col_o,
  output logic        reset_key_o,
  output logic        overflow_o
);

  localparam int PW = $clog2(RELQ_DEPTH);
  localparam logic [PW:0] QCAP = (PW + 1)'(RELQ_DEPTH);

  // 8 rows of 8 column bits, one bit per M5 key
  logic [7:0][7:0] matrix;

  // stage 1: latched PS/2 event
  logic       s1_valid;
  logic       s1_pressed;
  logic       s1_ext;
  logic [7:0] s1_code;

  logic [15:0] hold_timer;

  // deferred releases, stored as {row,bit}
  logic [5:0]    relq [RELQ_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   q_count;

  logic [6:0] hp;
  logic       map_hit;
  logic       map_reset;
  logic [5:0] map_pos;
  logic       timer_zero;
  logic       q_full;
  logic       ev_press;
  logic       ev_release;
  logic       defer;
  logic       imm_clear;
  logic       force_pop;
  logic       do_pop;
  logic [5:0] pop_pos;
  logic [7:0][7:0] mat_next;

  // PS/2 set-2 scan code -> {hit, row, bit}; octal literal digits read as 1,row,bit
  always_comb begin
    hp = 7'o000;
    case ({s1_ext, s1_code})
      9'h014: hp = 7'o100;  9'h011: hp = 7'o101;  9'h012: hp = 7'o105;  9'h059: hp = 7'o105;
      9'h029: hp = 7'o106;  9'h05A: hp = 7'o107;
      9'h01C: hp = 7'o110;  9'h01B: hp = 7'o111;  9'h023: hp = 7'o112;  9'h02B: hp = 7'o113;
      9'h034: hp = 7'o114;  9'h033: hp = 7'o115;  9'h03B: hp = 7'o116;  9'h042: hp = 7'o117;
      9'h04B: hp = 7'o120;  9'h01A: hp = 7'o121;  9'h022: hp = 7'o122;  9'h021: hp = 7'o123;
      9'h02A: hp = 7'o124;  9'h032: hp = 7'o125;  9'h031: hp = 7'o126;  9'h03A: hp = 7'o127;
      9'h015: hp = 7'o130;  9'h01D: hp = 7'o131;  9'h024: hp = 7'o132;  9'h02D: hp = 7'o133;
      9'h02C: hp = 7'o134;  9'h035: hp = 7'o135;  9'h03C: hp = 7'o136;  9'h043: hp = 7'o137;
      9'h044: hp = 7'o140;  9'h04D: hp = 7'o141;  9'h016: hp = 7'o142;  9'h01E: hp = 7'o143;
      9'h026: hp = 7'o144;  9'h025: hp = 7'o145;  9'h02E: hp = 7'o146;  9'h036: hp = 7'o147;
      9'h03D: hp = 7'o150;  9'h03E: hp = 7'o151;  9'h046: hp = 7'o152;  9'h045: hp = 7'o153;
      9'h04E: hp = 7'o154;  9'h041: hp = 7'o155;  9'h049: hp = 7'o156;  9'h04A: hp = 7'o157;
      9'h04C: hp = 7'o160;  9'h052: hp = 7'o161;  9'h054: hp = 7'o162;  9'h05B: hp = 7'o163;
      9'h055: hp = 7'o164;  9'h05D: hp = 7'o165;  9'h066: hp = 7'o166;  9'h076: hp = 7'o167;
      9'h16B: hp = 7'o170;  9'h175: hp = 7'o171;  9'h172: hp = 7'o172;  9'h174: hp = 7'o173;
      default: hp = 7'o000;
    endcase
  end

  assign map_hit    = hp[6];
  assign map_pos    = hp[5:0];
  assign map_reset  = ({s1_ext, s1_code} == 9'h007);

  assign timer_zero = (hold_timer == 16'd0);
  assign q_full     = (q_count == QCAP);
  assign ev_press   = s1_valid && map_hit && s1_pressed;
  assign ev_release = s1_valid && map_hit && !s1_pressed;
  assign defer      = ev_release && !timer_zero;
  assign imm_clear  = ev_release && timer_zero;
  // a full queue makes room by applying its oldest release now
  assign force_pop  = defer && q_full;
  assign do_pop     = force_pop || (timer_zero && (q_count != '0));
  assign pop_pos    = relq[rd_ptr];

  // next matrix: queued/immediate clears first, so a coincident press wins
  always_comb begin
    mat_next = matrix;
    if (do_pop) mat_next[pop_pos[5:3]][pop_pos[2:0]] = 1'b0;
    if (imm_clear) mat_next[map_pos[5:3]][map_pos[2:0]] = 1'b0;
    if (ev_press) mat_next[map_pos[5:3]][map_pos[2:0]] = 1'b1;
  end

  // event pipeline, hold timer, queue pointers and key state
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      matrix      <= '0;
      s1_valid    <= 1'b0;
      s1_pressed  <= 1'b0;
      s1_ext      <= 1'b0;
      s1_code     <= 8'h00;
      hold_timer  <= 16'd0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      q_count     <= '0;
      reset_key_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else if (clear_i) begin
      matrix      <= '0;
      s1_valid    <= 1'b0;
      hold_timer  <= 16'd0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      q_count     <= '0;
      reset_key_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      s1_valid <= ps2_key_i[10];
      if (ps2_key_i[10]) begin
        s1_pressed <= ps2_key_i[9];
        s1_ext     <= ps2_key_i[8];
        s1_code    <= ps2_key_i[7:0];
      end
      matrix <= mat_next;
      if (ev_press) hold_timer <= MIN_HOLD;
      else if (!timer_zero) hold_timer <= hold_timer - 16'd1;
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (defer) wr_ptr <= wr_ptr + PW'(1);
      if (defer && !do_pop) q_count <= q_count + (PW + 1)'(1);
      else if (do_pop && !defer) q_count <= q_count - (PW + 1)'(1);
      if (s1_valid && map_reset) reset_key_o <= s1_pressed;
      overflow_o <= force_pop;
    end
  end

  // queue storage; only written by a deferred release, which needs a valid stage-1 event
  always_ff @(posedge clk_i) begin
    if (defer && !clear_i) relq[wr_ptr] <= map_pos;
  end

  assign col_o = matrix[row_sel_i];

endmodule

// File: tb/tb_m5_key_matrix.sv
// tb/tb_m5_key_matrix.sv - randomized and directed bench for m5_key_matrix with a queue-based reference model
module tb_m5_key_matrix;

  localparam int HOLD  = 1000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        clear;
  logic [2:0]  row_sel;
  logic [7:0]  col;
  logic        reset_key;
  logic        overflow;

  m5_key_matrix #(.MIN_HOLD(16'd1000), .RELQ_DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .ps2_key_i(ps2_key), .clear_i(clear),
    .row_sel_i(row_sel), .col_o(col), .reset_key_o(reset_key), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  // key table: [16:8] = {extended, code}, [7:0] = row*8 + bit
  int unsigned tab [58] = '{
    'h01400, 'h01101, 'h01205, 'h05905, 'h02906, 'h05A07,
    'h01C08, 'h01B09, 'h0230A, 'h02B0B, 'h0340C, 'h0330D, 'h03B0E, 'h0420F,
    'h04B10, 'h01A11, 'h02212, 'h02113, 'h02A14, 'h03215, 'h03116, 'h03A17,
    'h01518, 'h01D19, 'h0241A, 'h02D1B, 'h02C1C, 'h0351D, 'h03C1E, 'h0431F,
    'h04420, 'h04D21, 'h01622, 'h01E23, 'h02624, 'h02525, 'h02E26, 'h03627,
    'h03D28, 'h03E29, 'h0462A, 'h0452B, 'h04E2C, 'h0412D, 'h0492E, 'h04A2F,
    'h04C30, 'h05231, 'h05432, 'h05B33, 'h05534, 'h05D35, 'h06636, 'h07637,
    'h16B38, 'h17539, 'h1723A, 'h1743B
  };

  int errors = 0;
  int checks = 0;
  int ovf_seen = 0;

  bit [7:0] m_mat [8];
  bit       m_rk;
  bit       m_ovf;
  int       m_timer;
  int       m_q[$];
  bit       p_valid;
  bit       p_pressed;
  bit [8:0] p_key;

  function automatic int lookup(bit [8:0] key);
    for (int i = 0; i < 58; i++)
      if (tab[i][16:8] == key) return int'(tab[i][7:0]);
    if (key == 9'h007) return 64;
    return -1;
  endfunction

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_mat[r] = 8'h00;
    m_rk = 0; m_ovf = 0; m_timer = 0; m_q.delete(); p_valid = 0;
  endtask

  // one clock of the key rules, evaluated on the inputs present before the edge
  task automatic model_step();
    int pos;
    int t0;
    int e;
    if (clear) begin
      model_reset();
      return;
    end
    t0 = m_timer;
    m_ovf = 0;
    pos = p_valid ? lookup(p_key) : -1;
    if (pos >= 0 && pos < 64 && p_pressed) m_timer = HOLD;
    else if (m_timer > 0) m_timer--;
    if (t0 == 0 && m_q.size() > 0) begin
      e = m_q.pop_front();
      m_mat[e / 8][e % 8] = 1'b0;
    end
    if (pos == 64) m_rk = p_pressed;
    else if (pos >= 0) begin
      if (p_pressed) m_mat[pos / 8][pos % 8] = 1'b1;
      else if (t0 == 0) m_mat[pos / 8][pos % 8] = 1'b0;
      else begin
        if (m_q.size() == DEPTH) begin
          e = m_q.pop_front();
          m_mat[e / 8][e % 8] = 1'b0;
          m_ovf = 1;
        end
        m_q.push_back(pos);
      end
    end
    p_valid = ps2_key[10];
    if (ps2_key[10]) begin
      p_pressed = ps2_key[9];
      p_key = ps2_key[8:0];
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("col", col, m_mat[row_sel]);
    chk("reset_key", {7'd0, reset_key}, {7'd0, m_rk});
    chk("overflow", {7'd0, overflow}, {7'd0, m_ovf});
    if (overflow) ovf_seen++;
  endtask

  task automatic idle(int n);
    repeat (n) cycle();
  endtask

  task automatic send(bit pr, bit [8:0] key);
    ps2_key = {1'b1, pr, key};
    cycle();
    ps2_key = '0;
  endtask

  task automatic all_rows_zero(string tag);
    for (int r = 0; r < 8; r++) begin
      row_sel = 3'(r);
      #1;
      chk(tag, col, 8'h00);
    end
  endtask

  initial begin
    int hold_len;
    int r;
    reset_n = 1'b0; ps2_key = '0; clear = 1'b0; row_sel = 3'd0;
    model_reset();
    #3;
    all_rows_zero("reset_col");
    chk("reset_rk", {7'd0, reset_key}, 8'h00);
    chk("reset_ovf", {7'd0, overflow}, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // press A, visible on row 1 two cycles after the strobe
    row_sel = 3'd1;
    send(1'b1, 9'h01C);
    chk("a_lat1", col, 8'h00);
    cycle();
    chk("a_lat2", col, 8'h01);
    for (int i = 0; i < 8; i++) begin
      if (i != 1) begin
        row_sel = 3'(i);
        #1;
        chk("a_other_row", col, 8'h00);
      end
    end
    row_sel = 3'd1;
    send(1'b0, 9'h01C);
    idle(1010);
    chk("a_expired", col, 8'h00);

    // space held short: stays set for the full hold time, then clears
    row_sel = 3'd0;
    send(1'b1, 9'h029);
    hold_len = 0;
    for (int i = 0; i < 1100; i++) begin
      if (i == 99) ps2_key = {2'b10, 9'h029};
      cycle();
      ps2_key = '0;
      if (col == 8'h40) hold_len++;
    end
    chk("space_hold_len", 8'(hold_len / 8), 8'(1001 / 8));
    chk("space_hold_len_lo", 8'(hold_len % 8), 8'(1001 % 8));

    // five quick press/release pairs overflow a 4-deep queue exactly once
    row_sel = 3'd1;
    ovf_seen = 0;
    for (int k = 0; k < 5; k++) begin
      send(1'b1, 9'(tab[7 + k][16:8]));
      idle(5);
      send(1'b0, 9'(tab[7 + k][16:8]));
      idle(5);
    end
    chk("burst_first_early", col & 8'h02, 8'h00);
    idle(1100);
    chk("burst_ovf_count", 8'(ovf_seen), 8'd1);
    chk("burst_cleared", col, 8'h00);

    // F12 drives reset_key directly, ignoring a running hold timer
    send(1'b1, 9'h01C);
    send(1'b1, 9'h007);
    cycle();
    chk("f12_press", {7'd0, reset_key}, 8'h01);
    send(1'b0, 9'h007);
    cycle();
    chk("f12_release", {7'd0, reset_key}, 8'h00);

    // clear wipes held keys and queued releases
    send(1'b1, 9'h16B);
    send(1'b1, 9'h012);
    idle(3);
    send(1'b0, 9'h16B);
    send(1'b0, 9'h012);
    clear = 1'b1;
    ps2_key = {2'b11, 9'h01C};
    cycle();
    clear = 1'b0;
    ps2_key = '0;
    all_rows_zero("clear_rows");
    row_sel = 3'd1;
    idle(2);
    chk("clear_beats_strobe", col, 8'h00);
    row_sel = 3'd7;
    idle(1100);

    // asynchronous reset with keys held and queue loaded
    row_sel = 3'd2;
    send(1'b1, 9'h04B);
    send(1'b1, 9'h01A);
    idle(2);
    send(1'b0, 9'h04B);
    send(1'b0, 9'h01A);
    chk("pre_reset_held", col, 8'h03);
    #1 reset_n = 1'b0;
    #1;
    chk("areset_col", col, 8'h00);
    chk("areset_rk", {7'd0, reset_key}, 8'h00);
    chk("areset_ovf", {7'd0, overflow}, 8'h00);
    ps2_key = {2'b11, 9'h01A};
    @(posedge clk);
    #1 ps2_key = '0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    model_reset();
    idle(1100);
    send(1'b1, 9'h01A);
    idle(2);
    chk("post_reset_press", col, 8'h02);
    idle(1010);

    // random bursts followed by long idles so queued releases drain
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 150; i++) begin
        row_sel = 3'($urandom_range(0, 7));
        clear = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 5) == 0) begin
          r = $urandom_range(0, 62);
          if (r < 58) ps2_key = {1'b1, 1'($urandom_range(0, 1)), 9'(tab[r][16:8])};
          else if (r == 59) ps2_key = {2'b1 << 1 | 2'($urandom_range(0, 1)), 9'h0FF};
          else if (r == 60) ps2_key = {1'b1, 1'($urandom_range(0, 1)), 9'h11C};
          else ps2_key = {1'b1, 1'($urandom_range(0, 1)), 9'h007};
        end
        cycle();
        ps2_key = '0;
        clear = 1'b0;
      end
      for (int i = 0; i < 1050; i++) begin
        row_sel = 3'($urandom_range(0, 7));
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
